// File: rtl/result_serializer.sv
// result_serializer: buffers result bytes in a small FIFO and shifts each one out
// on a single pin as a UART frame (start bit, 8 data bits LSB first, stop bit).
module result_serializer #(
   parameter int DEPTH        = 4,
   parameter int CLKS_PER_BIT = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [7:0]                 in_data,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic                       ovf_clr,
   output logic                       ser_out,
   output logic                       ser_busy,
   output logic [$clog2(DEPTH+1)-1:0] fifo_count,
   output logic                       overflow
);
   localparam int CW  = $clog2(DEPTH + 1);
   localparam int PW  = $clog2(DEPTH);
   localparam int CCW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0]  FULL     = CW'(DEPTH);
   localparam logic [CCW-1:0] CYC_LAST = CCW'(CLKS_PER_BIT - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

   logic [7:0]     mem_q [DEPTH];
   state_e         state_q, state_d;
   logic [PW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]  count_q, count_d;
   logic [CCW-1:0] cyc_q, cyc_d;
   logic [2:0]     bit_q, bit_d;
   logic [7:0]     shift_q, shift_d;
   logic           ser_out_q, ser_out_d, busy_q, busy_d, ovf_q, ovf_d;
   logic           push, pop, bit_end;

   assign in_ready = (count_q != FULL);
   assign push     = in_valid && in_ready;
   assign bit_end  = (cyc_q == CYC_LAST);
   // A new frame is loaded from IDLE or straight out of the last STOP cycle.
   assign pop      = (count_q != '0) && ((state_q == IDLE) || (state_q == STOP && bit_end));

   always_comb begin
      // NOTE: every always_comb output gets a default first so no latch is inferred.
      wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
      ovf_d = (in_valid && !in_ready) ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);

      state_d = state_q;
      cyc_d   = cyc_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      if (pop) begin
         state_d = START;
         cyc_d   = '0;
         bit_d   = '0;
         shift_d = mem_q[rd_ptr_q];
      end else if (state_q != IDLE) begin
         cyc_d = bit_end ? '0 : cyc_q + CCW'(1);
         if (bit_end) begin
            unique case (state_q)
               START: state_d = DATA;
               DATA: begin
                  shift_d = shift_q >> 1;
                  bit_d   = bit_q + 3'd1;
                  if (bit_q == 3'd7) state_d = STOP;
               end
               default: state_d = IDLE;
            endcase
         end
      end

      // Line level is computed from the next state so ser_out comes straight from a flop.
      case (state_d)
         START:   ser_out_d = 1'b0;
         DATA:    ser_out_d = shift_d[0];
         default: ser_out_d = 1'b1;
      endcase
      busy_d = (state_d != IDLE);
   end

   // NOTE: FIFO storage is deliberately not reset; count and pointers define validity.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= in_data;
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         cyc_q     <= '0;
         bit_q     <= '0;
         shift_q   <= '0;
         ser_out_q <= 1'b1;
         busy_q    <= 1'b0;
         ovf_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         cyc_q     <= cyc_d;
         bit_q     <= bit_d;
         shift_q   <= shift_d;
         ser_out_q <= ser_out_d;
         busy_q    <= busy_d;
         ovf_q     <= ovf_d;
      end
   end

   assign ser_out    = ser_out_q;
   assign ser_busy   = busy_q;
   assign fifo_count = count_q;
   assign overflow   = ovf_q;

endmodule

// File: tb/tb_result_serializer.sv
// Directed bench for result_serializer: frame timing, back-to-back frames,
// overflow handling, push/pop coincidence, pointer wrap and mid-frame reset.
`timescale 1ns/1ps
module tb_result_serializer;
   localparam int DEPTH = 4;
   localparam int CPB   = 4;
   localparam int CW    = $clog2(DEPTH + 1);

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [7:0]    in_data = 8'h00;
   logic          in_valid = 1'b0;
   logic          ovf_clr = 1'b0;
   logic          in_ready, ser_out, ser_busy, overflow;
   logic [CW-1:0] fifo_count;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   result_serializer #(.DEPTH(DEPTH), .CLKS_PER_BIT(CPB)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .ovf_clr    (ovf_clr),
      .ser_out    (ser_out),
      .ser_busy   (ser_busy),
      .fifo_count (fifo_count),
      .overflow   (overflow)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Line receiver: samples mid-bit, verifies start/stop levels, queues decoded bytes.
   logic [7:0] rx_q[$];
   logic [7:0] rx_sh = 8'h00;
   bit         rx_act = 1'b0;
   int         rx_j = 0;
   always @(negedge clk) begin
      if (rst_n !== 1'b1) rx_act = 1'b0;
      else begin
         if (rx_act) rx_j++;
         else if (ser_out === 1'b0) begin
            rx_act = 1'b1;
            rx_j   = 0;
         end
         if (rx_act && (rx_j % CPB) == CPB / 2) begin
            if (rx_j / CPB == 0) check("rx_start", ser_out, 0);
            else if (rx_j / CPB <= 8) rx_sh[rx_j / CPB - 1] = ser_out;
            else begin
               check("rx_stop", ser_out, 1);
               rx_q.push_back(rx_sh);
            end
         end
         if (rx_act && rx_j == 10 * CPB - 1) rx_act = 1'b0;
      end
   end

   int busy_cnt = 0;
   int busy_starts = 0;
   bit busy_prev = 1'b0;
   always @(negedge clk) begin
      if (ser_busy === 1'b1) begin
         busy_cnt++;
         if (!busy_prev) busy_starts++;
      end
      busy_prev = (ser_busy === 1'b1);
   end

   logic [7:0] exp_q[$];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_push(input logic [7:0] b);
      in_data  = b;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic check_rx(input string tag);
      check({tag, "_n"}, rx_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
         check($sformatf("%s_%0d", tag, i), rx_q[i], exp_q[i]);
      rx_q.delete();
      exp_q.delete();
   endtask

   task automatic wait_idle(input string tag);
      int n;
      n = 0;
      @(negedge clk);
      while ((ser_busy !== 1'b0 || fifo_count !== '0) && n < 1000) begin
         @(negedge clk);
         n++;
      end
      check(tag, ser_busy, 0);
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   logic [9:0] frame;
   int         n;
   int         low_cnt;

   initial begin
      repeat (2) @(posedge clk);
      #1;
      check("rst_ser_out", ser_out, 1);
      check("rst_busy", ser_busy, 0);
      check("rst_count", fifo_count, 0);
      check("rst_ovf", overflow, 0);
      check("rst_ready", in_ready, 1);
      rst_n = 1'b1;
      tick();
      check("post_rst_ser_out", ser_out, 1);

      // Single byte: exact waveform, one edge of latency, 40 busy cycles.
      busy_cnt = 0; busy_starts = 0;
      drive_push(8'h66);
      @(negedge clk);
      check("t1_count1", fifo_count, 1);
      check("t1_out_before", ser_out, 1);
      check("t1_busy_before", ser_busy, 0);
      frame = {1'b1, 8'h66, 1'b0};
      for (int j = 0; j < 10 * CPB; j++) begin
         @(negedge clk);
         check($sformatf("t1_bit%0d", j), ser_out, frame[j / CPB]);
         if (j == 0) begin
            check("t1_count0", fifo_count, 0);
            check("t1_busy", ser_busy, 1);
         end
      end
      @(negedge clk);
      check("t1_idle_out", ser_out, 1);
      check("t1_idle_busy", ser_busy, 0);
      check("t1_busy_cnt", busy_cnt, 40);
      check("t1_busy_starts", busy_starts, 1);
      exp_q = {8'h66};
      check_rx("t1_rx");
      tick();

      // Back-to-back: three contiguous frames.
      busy_cnt = 0; busy_starts = 0;
      drive_push(8'h66);
      drive_push(8'hCC);
      drive_push(8'h00);
      wait_idle("t2_idle");
      check("t2_busy_cnt", busy_cnt, 120);
      check("t2_busy_starts", busy_starts, 1);
      exp_q = {8'h66, 8'hCC, 8'h00};
      check_rx("t2_rx");

      // Fill to full, overflow, set-wins-over-clear, then clear.
      for (int i = 1; i <= 6; i++) begin
         in_data  = 8'(i);
         in_valid = 1'b1;
         if (i == 6) begin
            @(negedge clk);
            check("t3_count_full", fifo_count, 4);
            check("t3_ready_low", in_ready, 0);
            check("t3_ovf_before", overflow, 0);
         end
         tick();
      end
      in_valid = 1'b0;
      @(negedge clk);
      check("t3_ovf_set", overflow, 1);
      check("t3_count_hold", fifo_count, 4);
      in_data = 8'h77; in_valid = 1'b1; ovf_clr = 1'b1;
      tick();
      in_valid = 1'b0;
      @(negedge clk);
      check("t3_set_wins", overflow, 1);
      @(posedge clk);
      #1;
      ovf_clr = 1'b0;
      @(negedge clk);
      check("t3_ovf_clr", overflow, 0);
      wait_idle("t3_idle");
      check("t3_ovf_stays", overflow, 0);
      exp_q = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
      check_rx("t3_rx");

      // Push exactly at the last STOP edge with two bytes queued.
      busy_cnt = 0; busy_starts = 0;
      drive_push(8'h3C);
      drive_push(8'hC3);
      drive_push(8'h5A);
      repeat (38) @(posedge clk);
      #1;
      @(negedge clk);
      check("t4_count_pre", fifo_count, 2);
      check("t4_stop_bit", ser_out, 1);
      in_data = 8'hA5; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      @(negedge clk);
      check("t4_count_same", fifo_count, 2);
      check("t4_no_gap", ser_out, 0);
      check("t4_busy", ser_busy, 1);
      wait_idle("t4_idle");
      check("t4_busy_cnt", busy_cnt, 160);
      check("t4_busy_starts", busy_starts, 1);
      exp_q = {8'h3C, 8'hC3, 8'h5A, 8'hA5};
      check_rx("t4_rx");

      // Throttled stream of 12 bytes wraps the pointers several times.
      for (int i = 0; i < 12; i++) begin
         n = 0;
         @(negedge clk);
         while (fifo_count >= CW'(DEPTH - 1) && n < 400) begin
            @(negedge clk);
            n++;
         end
         in_data  = 8'hA0 + 8'(i);
         in_valid = 1'b1;
         exp_q.push_back(8'hA0 + 8'(i));
         @(posedge clk);
         #1;
         in_valid = 1'b0;
      end
      wait_idle("t5_idle");
      check("t5_ovf", overflow, 0);
      check_rx("t5_rx");

      // Asynchronous reset in the middle of a DATA phase.
      drive_push(8'h55);
      drive_push(8'h11);
      drive_push(8'h22);
      repeat (12) @(posedge clk);
      #1;
      check("t6_busy_pre", ser_busy, 1);
      check("t6_count_pre", fifo_count, 2);
      rst_n = 1'b0;
      #1;
      check("t6_rst_out", ser_out, 1);
      check("t6_rst_count", fifo_count, 0);
      check("t6_rst_busy", ser_busy, 0);
      check("t6_rst_ready", in_ready, 1);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      busy_cnt = 0; busy_starts = 0;
      low_cnt = 0;
      repeat (60) begin
         @(negedge clk);
         if (ser_out !== 1'b1) low_cnt++;
      end
      check("t6_line_idle", low_cnt, 0);
      check("t6_no_busy", busy_starts, 0);
      check("t6_count_idle", fifo_count, 0);
      check_rx("t6_rx_none");
      tick();
      drive_push(8'hA5);
      wait_idle("t6_idle");
      exp_q = {8'hA5};
      check_rx("t6_rx_after");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
